uart_rx_oversampled: RTL and testbench
======================================

Name: uart_rx_oversampled

Overview:
- UART receiver; the consuming end of the baud tick generator.
- Takes an oversampled tick (Baud × Oversampling) and a raw serial line.
- Synchronises the line, detects and validates start bits, samples data bits at mid-bit, and checks the stop bit.
- Presents each received word with a ready/ack handshake to the downstream FIR/control logic, plus framing-error and overrun status.

Parameters:
- Oversampling, 16: ticks per bit period. Even, ≥ 4.
- DataBits, 8: data bits per frame, LSB first. Range 5–9.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- tick  input  1  one-clk pulse at Baud×Oversampling rate from the tick generator.
- rx  input  1  raw serial line, idle high, asynchronous to clk.
- data_ack  input  1  downstream consumes data_out; effective only while data_ready=1.
- data_out  output  DataBits  last good received word.
- data_ready  output  1  data_out holds an unconsumed word.
- frame_err  output  1  one-clk pulse: stop bit sampled low.
- overrun  output  1  sticky; a good word arrived while data_ready=1.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, async):
  - State IDLE; sample counter and bit counter 0; shift register 0.
  - data_out=0, data_ready=0, frame_err=0, overrun=0, busy=0.
  - Both synchroniser flops and the previous-sample flop reset to 1, so leaving reset never produces a false start.
  - Reset mid-frame abandons the frame; nothing is delivered.
- rx path: 2-flop synchroniser → rx_s; rx_p = rx_s delayed 1 clk. Falling edge = rx_p=1 && rx_s=0.
- All counters advance only on clk edges where tick=1, except the IDLE start-edge check, which is evaluated every clk.
- Sample counter s_cnt width: $clog2(Oversampling).
- States:
  - IDLE:
    - On falling edge → START, s_cnt=0.
    - A line held low (break) does not retrigger.
  - START:
    - Each tick increments s_cnt.
    - On the tick where s_cnt == Oversampling/2−1, check rx_s:
      - rx_s=0 → DATA, s_cnt=0, bit_cnt=0.
      - rx_s=1 (glitch) → IDLE, no status change.
  - DATA:
    - Each tick increments s_cnt.
    - On the tick where s_cnt == Oversampling−1:
      - Shift rx_s into the MSB of the shift register (right shift, so the LSB-first word lands aligned); s_cnt=0; bit_cnt++.
      - After the DataBits-th sample → STOP.
  - STOP:
    - On the tick where s_cnt == Oversampling−1, sample rx_s, then → IDLE.
    - rx_s=1: data_out ← shift register. On the next clk edge, data_ready=1.
      - If data_ready was already 1 and data_ack is not asserted that cycle, overrun ← 1.
    - rx_s=0: frame_err=1 for exactly one clk; data_out, data_ready and overrun unchanged.
- Latency: data_ready rises on the clk edge that registers the stop-bit sample. From the centre of the start bit, that is (DataBits+1)×Oversampling ticks.
- Handshake:
  - data_ready=1 && data_ack=1 → data_ready=0 and overrun=0 on the next edge.
  - data_ack while data_ready=0 is ignored.
- Simultaneous delivery and data_ack:
  - New word loaded; data_ready stays 1; overrun not set; data_ack does not clear the new word.
  - Any previously set overrun is cleared.
- Overrun policy: the new word overwrites data_out; overrun stays 1 until data_ack.
- tick held high continuously is legal: one increment per clk.
- busy = (state ≠ IDLE), registered with the state.

Test Plan:
- Clean frame: tick every 4 clks, Oversampling=16, send 0xA5 (start, 1,0,1,0,0,1,0,1 LSB first, stop) → data_out=0xA5, data_ready=1 exactly (9×16)×4 clks after the start-bit centre ±2 clk. frame_err=0, overrun=0.
- Glitch rejection: rx low for 5 ticks then high → state returns to IDLE, busy drops, no data_ready, no frame_err. A following 0x3C frame is received correctly.
- Framing error: send 0x81 with the stop bit driven low → frame_err one-clk pulse, data_ready stays 0, data_out keeps its previous value. A 1 ms break does not retrigger START until rx goes high and falls again.
- Overrun: receive 0x11 without ack, then 0x22 → data_out=0x22, data_ready=1, overrun=1. data_ack for one clk → data_ready=0, overrun=0.
- Ack coincident with delivery: hold data_ack=1 across completion of 0x5A while 0x11 is pending → data_out=0x5A, data_ready=1, overrun=0.
- Reset mid-frame: assert rst low during bit 3 of 0xFF, release → all outputs 0, busy=0. Next 0x0F frame is received correctly with no spurious start.

Source files
------------

// File: rtl/uart_rx_oversampled.sv
`default_nettype none
// ==========================================================================
// uart_rx_oversampled : oversampled UART receiver with ready/ack delivery,
//                       framing-error pulse and sticky overrun status.
// Rev 1.0
// ==========================================================================
module uart_rx_oversampled #(
  parameter int OVERSAMPLING = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rx,
  input  logic                 data_ack,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int SW = $clog2(OVERSAMPLING);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLING / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLING - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic                   sync1_q, sync1_d;
  logic                   sync2_q, sync2_d;
  logic                   prev_q, prev_d;
  logic [SW-1:0]          s_cnt_q, s_cnt_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_out_q, data_out_d;
  logic                   data_ready_q, data_ready_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic                   busy_q, busy_d;

  always_comb begin
    sync1_d      = rx;
    sync2_d      = sync1_q;
    prev_d       = sync2_q;
    state_d      = state_q;
    s_cnt_d      = s_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    data_out_d   = data_out_q;
    data_ready_d = data_ready_q;
    overrun_d    = overrun_q;
    frame_err_d  = 1'b0;

    if (data_ready_q && data_ack) begin
      data_ready_d = 1'b0;
      overrun_d    = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // Only a true high-to-low transition starts a frame; a held break does not.
        if (prev_q && !sync2_q) begin
          state_d = START;
          s_cnt_d = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s_cnt_q == S_HALF) begin
            s_cnt_d   = '0;
            bit_cnt_d = '0;
            state_d   = sync2_q ? IDLE : DATA;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_cnt_q == S_LAST) begin
            s_cnt_d   = '0;
            shift_d   = {sync2_q, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == B_LAST) state_d = STOP;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_cnt_q == S_LAST) begin
            s_cnt_d = '0;
            state_d = IDLE;
            if (sync2_q) begin
              // A coincident ack consumes the old word, never the one arriving now.
              data_out_d   = shift_q;
              data_ready_d = 1'b1;
              if (data_ready_q && !data_ack) overrun_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      prev_q       <= 1'b1;
      s_cnt_q      <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      data_out_q   <= '0;
      data_ready_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      prev_q       <= prev_d;
      s_cnt_q      <= s_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      data_ready_q <= data_ready_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_ready = data_ready_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_oversampled.sv
`default_nettype none
// ==========================================================================
// tb_uart_rx_oversampled : directed scoreboard bench for uart_rx_oversampled.
// Rev 1.0
// ==========================================================================
module tb_uart_rx_oversampled;
  localparam int OS       = 16;
  localparam int DB       = 8;
  localparam int TDIV     = 4;
  localparam int BIT_CLKS = OS * TDIV;
  localparam int LATENCY  = (DB + 1) * OS * TDIV + BIT_CLKS / 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick = 1'b0;
  logic          rx = 1'b1;
  logic          data_ack = 1'b0;
  logic [DB-1:0] data_out;
  logic          data_ready;
  logic          frame_err;
  logic          overrun;
  logic          busy;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            rise_cyc = -1;
  int            ferr_cnt = 0;
  int            ferr_base;
  int            t0;
  logic          ready_prev = 1'b0;
  logic [DB-1:0] exp_q[$];

  uart_rx_oversampled #(.OVERSAMPLING(OS), .DATA_BITS(DB)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .rx         (rx),
    .data_ack   (data_ack),
    .data_out   (data_out),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Tick lands on every posedge whose index is a multiple of TDIV.
  initial begin
    forever begin
      @(negedge clk);
      tick = (((cyc + 1) % TDIV) == 0);
    end
  end

  always @(negedge clk) begin
    if (data_ready && !ready_prev) rise_cyc = cyc;
    ready_prev = data_ready;
    if (frame_err) ferr_cnt = ferr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic align();
    do @(negedge clk); while ((cyc % TDIV) != 0);
  endtask

  task automatic send_frame(input logic [DB-1:0] w, input logic stop_lvl, input logic ack_at_stop);
    align();
    t0       = cyc;
    rise_cyc = -1;
    rx       = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < DB; i++) begin
      rx = w[i];
      wait_clks(BIT_CLKS);
    end
    rx = stop_lvl;
    if (stop_lvl) exp_q.push_back(w);
    if (ack_at_stop) begin
      wait_clks(BIT_CLKS / 2 - 1);
      data_ack = 1'b1;
      wait_clks(1);
      data_ack = 1'b0;
      wait_clks(BIT_CLKS / 2);
    end else begin
      wait_clks(BIT_CLKS);
    end
  endtask

  task automatic check_delivery(input string tag);
    logic [DB-1:0] e;
    chk({tag, "_sb_nonempty"}, (exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_data_out"}, data_out, e);
      chk({tag, "_data_ready"}, data_ready, 1'b1);
    end
  endtask

  task automatic pulse_ack();
    data_ack = 1'b1;
    wait_clks(1);
    data_ack = 1'b0;
    wait_clks(1);
  endtask

  initial begin
    int diff;
    rst = 1'b0;
    wait_clks(5);
    chk("rst_data_out", data_out, 0);
    chk("rst_data_ready", data_ready, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    wait_clks(10);
    chk("idle_after_rst_busy", busy, 0);

    // Clean frame with latency check.
    send_frame(8'hA5, 1'b1, 1'b0);
    diff = rise_cyc - t0;
    checks++;
    assert (diff >= LATENCY - 2 && diff <= LATENCY + 2) else begin
      errors++;
      $error("FAIL latency observed=%0d expected=%0d+-2", diff, LATENCY);
    end
    check_delivery("a5");
    chk("a5_frame_err", ferr_cnt, 0);
    chk("a5_overrun", overrun, 0);
    pulse_ack();
    chk("a5_ack_ready", data_ready, 0);

    // Glitch shorter than half a bit.
    align();
    rx = 1'b0;
    wait_clks(10);
    chk("glitch_busy_high", busy, 1);
    wait_clks(5 * TDIV - 10);
    rx = 1'b1;
    wait_clks(40);
    chk("glitch_busy_low", busy, 0);
    chk("glitch_ready", data_ready, 0);
    chk("glitch_frame_err", ferr_cnt, 0);
    send_frame(8'h3C, 1'b1, 1'b0);
    check_delivery("3c");
    pulse_ack();

    // Framing error followed by a held break.
    ferr_base = ferr_cnt;
    send_frame(8'h81, 1'b0, 1'b0);
    chk("ferr_pulse_count", ferr_cnt - ferr_base, 1);
    chk("ferr_ready", data_ready, 0);
    chk("ferr_data_kept", data_out, 8'h3C);
    chk("ferr_overrun", overrun, 0);
    wait_clks(20 * BIT_CLKS);
    chk("break_busy", busy, 0);
    chk("break_no_more_ferr", ferr_cnt - ferr_base, 1);
    rx = 1'b1;
    wait_clks(BIT_CLKS);

    // Overrun.
    send_frame(8'h11, 1'b1, 1'b0);
    check_delivery("ovr_11");
    chk("ovr_11_overrun", overrun, 0);
    send_frame(8'h22, 1'b1, 1'b0);
    check_delivery("ovr_22");
    chk("ovr_22_overrun", overrun, 1);
    pulse_ack();
    chk("ovr_ack_ready", data_ready, 0);
    chk("ovr_ack_overrun", overrun, 0);

    // Ack coincident with delivery while an overrun is already flagged.
    send_frame(8'h11, 1'b1, 1'b0);
    check_delivery("co_11");
    send_frame(8'h33, 1'b1, 1'b0);
    check_delivery("co_33");
    chk("co_33_overrun", overrun, 1);
    send_frame(8'h5A, 1'b1, 1'b1);
    check_delivery("co_5a");
    chk("co_5a_overrun", overrun, 0);

    // Reset in the middle of bit 3 of 0xFF, with 0x5A still pending.
    align();
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    rx = 1'b1;
    wait_clks(3 * BIT_CLKS + BIT_CLKS / 2);
    chk("midrst_busy_before", busy, 1);
    rst = 1'b0;
    wait_clks(3);
    chk("midrst_data_out", data_out, 0);
    chk("midrst_ready", data_ready, 0);
    chk("midrst_frame_err", frame_err, 0);
    chk("midrst_overrun", overrun, 0);
    chk("midrst_busy", busy, 0);
    rst = 1'b1;
    wait_clks(6 * BIT_CLKS);
    chk("midrst_no_start_busy", busy, 0);
    chk("midrst_no_start_ready", data_ready, 0);
    send_frame(8'h0F, 1'b1, 1'b0);
    check_delivery("0f");
    chk("0f_overrun", overrun, 0);
    pulse_ack();
    chk("0f_ack_ready", data_ready, 0);
    chk("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
